// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite arbiter slice.
//   RESP_OKAY / RESP_SLVERR : AXI response codes used on B and R channels.
//   arb_state_t             : arbiter FSM states, also exported on the debug
//                             state output of axi4_lite_arbiter.
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD      = 3'd3,
      RD_DATA = 3'd4
   } arb_state_t;

endpackage

// File: rtl/axi4_lite_rr_picker.sv
// -----------------------------------------------------------------------------
// axi4_lite_rr_picker
// Combinational round-robin picker. Scans the request vector starting at
// ptr_i and wrapping modulo NUM; the first set bit found wins. With ptr_i
// tied to zero it degenerates into lowest-index-wins fixed priority, which is
// how the arbiter builds its AXIL_ARB_FIXED_PRIO_EN variant.
// Ports:
//   req_i   [NUM]         request per master
//   ptr_i   [$clog2(NUM)] index searched first
//   idx_o   [$clog2(NUM)] winning index (0 when nobody requests)
//   valid_o               at least one request present
// -----------------------------------------------------------------------------
module axi4_lite_rr_picker
   import axi4_lite_pkg::*;
#(
   parameter int NUM = 2
) (
   input  logic [NUM-1:0]         req_i,
   input  logic [$clog2(NUM)-1:0] ptr_i,
   output logic [$clog2(NUM)-1:0] idx_o,
   output logic                   valid_o
);

   logic [$clog2(NUM)-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester to ptr_i
   // is the last assignment and therefore wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = NUM - 1; k >= 0; k--) begin
         cand = ($clog2(NUM))'((int'(ptr_i) + k) % NUM);
         if (req_i[cand]) begin
            idx_o   = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_lite_arbiter
// Shares one AXI4-Lite slave between NUM_MASTERS masters, one complete read or
// write transaction at a time, with round-robin fairness.
//
// Build option: define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, rr_ptr held at 0). Default build is round-robin.
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   M_AW*/M_W*/M_B*     per-master write channels (addr/data packed, master i
//                       at slice i); M_BRESP broadcast
//   M_AR*/M_R*          per-master read channels; M_RDATA/M_RRESP broadcast
//   S_*                 single master-side interface towards the slave
//   GRANT               index of current or last owner
//   BUSY                transaction in flight (state != IDLE)
//   DBG_STATE           current FSM state
//
// Handshake semantics: every channel transfers on a clock edge where VALID and
// READY are both high. Only the granted master ever sees READY (AW/W/AR) or
// VALID (B/R) high; every other master sees them low. Slave-side VALIDs only
// rise in the FSM state that owns the channel, and AW/W VALIDs drop as soon as
// that channel has transferred, so a master queuing its next W beat early
// cannot leak it into the current transaction.
// -----------------------------------------------------------------------------
module axi4_lite_arbiter
   import axi4_lite_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDRESS     = 32
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   // masters: write address
   input  logic [NUM_MASTERS-1:0]            M_AWVALID,
   output logic [NUM_MASTERS-1:0]            M_AWREADY,
   input  logic [NUM_MASTERS*ADDRESS-1:0]    M_AWADDR,
   // masters: write data
   input  logic [NUM_MASTERS-1:0]            M_WVALID,
   output logic [NUM_MASTERS-1:0]            M_WREADY,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_WDATA,
   input  logic [NUM_MASTERS*4-1:0]          M_WSTRB,
   // masters: write response
   output logic [NUM_MASTERS-1:0]            M_BVALID,
   input  logic [NUM_MASTERS-1:0]            M_BREADY,
   output logic [1:0]                        M_BRESP,
   // masters: read address
   input  logic [NUM_MASTERS-1:0]            M_ARVALID,
   output logic [NUM_MASTERS-1:0]            M_ARREADY,
   input  logic [NUM_MASTERS*ADDRESS-1:0]    M_ARADDR,
   // masters: read data
   output logic [NUM_MASTERS-1:0]            M_RVALID,
   input  logic [NUM_MASTERS-1:0]            M_RREADY,
   output logic [DATA_WIDTH-1:0]             M_RDATA,
   output logic [1:0]                        M_RRESP,
   // slave side
   output logic [ADDRESS-1:0]                S_AWADDR,
   output logic                              S_AWVALID,
   input  logic                              S_AWREADY,
   output logic [DATA_WIDTH-1:0]             S_WDATA,
   output logic [3:0]                        S_WSTRB,
   output logic                              S_WVALID,
   input  logic                              S_WREADY,
   input  logic [1:0]                        S_BRESP,
   input  logic                              S_BVALID,
   output logic                              S_BREADY,
   output logic [ADDRESS-1:0]                S_ARADDR,
   output logic                              S_ARVALID,
   input  logic                              S_ARREADY,
   input  logic [DATA_WIDTH-1:0]             S_RDATA,
   input  logic [1:0]                        S_RRESP,
   input  logic                              S_RVALID,
   output logic                              S_RREADY,
   // status
   output logic [$clog2(NUM_MASTERS)-1:0]    GRANT,
   output logic                              BUSY,
   output arb_state_t                        DBG_STATE
);

   localparam int GW = $clog2(NUM_MASTERS);

   arb_state_t    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;

   // ---------------------------------------------------------------- unpack
   logic [ADDRESS-1:0]    awaddr_a [NUM_MASTERS];
   logic [ADDRESS-1:0]    araddr_a [NUM_MASTERS];
   logic [DATA_WIDTH-1:0] wdata_a  [NUM_MASTERS];
   logic [3:0]            wstrb_a  [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign awaddr_a[i] = M_AWADDR[i*ADDRESS +: ADDRESS];
      assign araddr_a[i] = M_ARADDR[i*ADDRESS +: ADDRESS];
      assign wdata_a[i]  = M_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_a[i]  = M_WSTRB[i*4 +: 4];
   end

   // ---------------------------------------------------------------- picker
   logic [NUM_MASTERS-1:0] req;
   logic [GW-1:0]          pick_idx;
   logic                   pick_valid;
   logic [GW-1:0]          ptr_after;

   assign req = M_AWVALID | M_ARVALID;

   // In the fixed-priority build rr_ptr never leaves 0, so feeding it to the
   // picker is the same as tying the pointer to zero.
   axi4_lite_rr_picker #(.NUM(NUM_MASTERS)) u_picker (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

`ifdef AXIL_ARB_FIXED_PRIO_EN
   assign ptr_after = '0;
`else
   assign ptr_after = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
`endif

   // ---------------------------------------------------------------- state decode
   logic in_wr, in_wr_resp, in_rd, in_rd_data;

   assign in_wr      = (state_q == WR);
   assign in_wr_resp = (state_q == WR_RESP);
   assign in_rd      = (state_q == RD);
   assign in_rd_data = (state_q == RD_DATA);

   // ---------------------------------------------------------------- slave side mux
   assign S_AWADDR  = awaddr_a[grant_q];
   assign S_AWVALID = in_wr && !aw_done_q && M_AWVALID[grant_q];
   assign S_WDATA   = wdata_a[grant_q];
   assign S_WSTRB   = wstrb_a[grant_q];
   assign S_WVALID  = in_wr && !w_done_q && M_WVALID[grant_q];
   assign S_BREADY  = in_wr_resp && M_BREADY[grant_q];
   assign S_ARADDR  = araddr_a[grant_q];
   assign S_ARVALID = in_rd && M_ARVALID[grant_q];
   assign S_RREADY  = in_rd_data && M_RREADY[grant_q];

   // ---------------------------------------------------------------- master side demux
   assign M_BRESP = S_BRESP;
   assign M_RDATA = S_RDATA;
   assign M_RRESP = S_RRESP;

   always_comb begin
      M_AWREADY = '0;
      M_WREADY  = '0;
      M_ARREADY = '0;
      M_BVALID  = '0;
      M_RVALID  = '0;
      M_AWREADY[grant_q] = in_wr && !aw_done_q && S_AWREADY;
      M_WREADY[grant_q]  = in_wr && !w_done_q && S_WREADY;
      M_ARREADY[grant_q] = in_rd && S_ARREADY;
      M_BVALID[grant_q]  = in_wr_resp && S_BVALID;
      M_RVALID[grant_q]  = in_rd_data && S_RVALID;
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d   = pick_idx;
               // a master asking for both gets its write served first; the
               // read stays requested and wins a later grant
               state_d   = M_AWVALID[pick_idx] ? WR : RD;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         WR: begin
            if (S_AWVALID && S_AWREADY) aw_done_d = 1'b1;
            if (S_WVALID && S_WREADY)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)  state_d   = WR_RESP;
         end
         WR_RESP: begin
            if (S_BVALID && S_BREADY) begin
               state_d   = IDLE;
               rr_ptr_d  = ptr_after;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         RD: begin
            if (S_ARVALID && S_ARREADY) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (S_RVALID && S_RREADY) begin
               state_d  = IDLE;
               rr_ptr_d = ptr_after;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign GRANT     = grant_q;
   assign BUSY      = (state_q != IDLE);
   assign DBG_STATE = state_q;

endmodule
